// File: rtl/corr_regs_pkg.sv
// Register map, FSM state encoding and dump field layout shared by the
// correlator dump master and its Wishbone access engine.
package corr_regs_pkg;

    localparam logic [11:0] OFS_PRN     = 12'h000;
    localparam logic [11:0] OFS_CARR    = 12'h004;
    localparam logic [11:0] OFS_CODE    = 12'h008;
    localparam logic [11:0] OFS_SLEW    = 12'h00C;
    localparam logic [11:0] OFS_IE      = 12'h010;
    localparam logic [11:0] OFS_QE      = 12'h014;
    localparam logic [11:0] OFS_IP      = 12'h018;
    localparam logic [11:0] OFS_QP      = 12'h01C;
    localparam logic [11:0] OFS_IL      = 12'h020;
    localparam logic [11:0] OFS_QL      = 12'h024;
    localparam logic [11:0] OFS_STATUS  = 12'h380;
    localparam logic [11:0] OFS_NEWDATA = 12'h384;

    // dump_corr is {ql,il,qp,ip,qe,ie}; field k lives at [k*CORR_W +: CORR_W]
    localparam int CORR_W  = 32;
    localparam int CORR_IE = 0;
    localparam int CORR_QE = 1;
    localparam int CORR_IP = 2;
    localparam int CORR_QP = 3;
    localparam int CORR_IL = 4;
    localparam int CORR_QL = 5;
    localparam int CORR_N  = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_STAT,
        ST_RD_NEWDATA,
        ST_RD_IE,
        ST_RD_QE,
        ST_RD_IP,
        ST_RD_QP,
        ST_RD_IL,
        ST_RD_QL,
        ST_DUMP,
        ST_WAIT_UPD,
        ST_WR_SLEW,
        ST_WR_CODE,
        ST_WR_CARR
    } corr_state_e;

    function automatic logic is_access(input corr_state_e s);
        return s inside {ST_RD_STAT, ST_RD_NEWDATA, ST_RD_IE, ST_RD_QE, ST_RD_IP,
                         ST_RD_QP, ST_RD_IL, ST_RD_QL, ST_WR_SLEW, ST_WR_CODE, ST_WR_CARR};
    endfunction

    // Next write state after 'after'; zero words are skipped without a bus access.
    function automatic corr_state_e next_write(input corr_state_e after,
                                               input logic [31:0] slew,
                                               input logic [31:0] code,
                                               input logic [31:0] carr);
        corr_state_e nxt;
        nxt = ST_IDLE;
        if ((after inside {ST_WAIT_UPD, ST_WR_SLEW, ST_WR_CODE}) && carr != '0)
            nxt = ST_WR_CARR;
        if ((after inside {ST_WAIT_UPD, ST_WR_SLEW}) && code != '0)
            nxt = ST_WR_CODE;
        if (after == ST_WAIT_UPD && slew != '0)
            nxt = ST_WR_SLEW;
        return nxt;
    endfunction

endpackage

// File: rtl/wb_single_access.sv
// Runs one Wishbone classic read or write with an ack timeout. done/err are
// combinational in the last bus cycle; cyc drops on the following edge.
module wb_single_access #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign done  = wb_cyc_o & wb_ack_i;
    assign err   = wb_cyc_o & ~wb_ack_i & (cnt == CW'(ACK_TIMEOUT - 1));
    assign rdata = wb_dat_i;

    // A start can only be seen while cyc is low, and the sequencer raises it
    // one cycle after done, so every access is followed by one idle gap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            cnt      <= '0;
        end else if (!wb_cyc_o) begin
            if (start) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= we;
                wb_adr_o <= adr;
                wb_dat_o <= wdat;
                cnt      <= '0;
            end
        end else if (done || err) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/corr_dump_master.sv
// Hardware replacement for the correlator accumulation ISR: reads status and
// accumulations over Wishbone, hands them to the loop filter, writes results back.
module corr_dump_master
    import corr_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter logic [11:0] STATUS_OFS  = OFS_STATUS,
    parameter logic [11:0] NEWDATA_OFS = OFS_NEWDATA,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         hw_rst,
    input  logic         enable,
    input  logic         accum_int,
    output logic [31:0]  wb_adr_o,
    output logic [31:0]  wb_dat_o,
    input  logic [31:0]  wb_dat_i,
    output logic [3:0]   wb_sel_o,
    output logic         wb_cyc_o,
    output logic         wb_stb_o,
    output logic         wb_we_o,
    input  logic         wb_ack_i,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [191:0] dump_corr,
    output logic [31:0]  dump_status,
    input  logic         upd_valid,
    output logic         upd_ready,
    input  logic [31:0]  upd_slew,
    input  logic [31:0]  upd_code_freq,
    input  logic [31:0]  upd_carr_freq,
    output logic         busy,
    output logic         err_timeout,
    output logic         missed_int
);

    corr_state_e state;
    logic        int_d;
    logic        int_evt;
    logic        issued;
    logic        acc_start;
    logic        acc_we;
    logic        acc_done;
    logic        acc_err;
    logic [11:0] acc_ofs;
    logic [31:0] acc_adr;
    logic [31:0] acc_wdat;
    logic [31:0] acc_rdata;
    logic [31:0] slew_q;
    logic [31:0] code_q;
    logic [31:0] carr_q;

    assign int_evt   = accum_int & ~int_d;
    assign busy      = (state != ST_IDLE);
    assign wb_sel_o  = 4'hf;
    assign acc_start = is_access(state) & ~issued;
    assign acc_adr   = BASE_ADDR + {20'h0, acc_ofs};

    always_comb begin
        acc_ofs  = OFS_PRN;
        acc_we   = 1'b0;
        acc_wdat = '0;
        unique case (state)
            ST_RD_STAT:    acc_ofs = STATUS_OFS;
            ST_RD_NEWDATA: acc_ofs = NEWDATA_OFS;
            ST_RD_IE:      acc_ofs = OFS_IE;
            ST_RD_QE:      acc_ofs = OFS_QE;
            ST_RD_IP:      acc_ofs = OFS_IP;
            ST_RD_QP:      acc_ofs = OFS_QP;
            ST_RD_IL:      acc_ofs = OFS_IL;
            ST_RD_QL:      acc_ofs = OFS_QL;
            ST_WR_SLEW: begin
                acc_ofs  = OFS_SLEW;
                acc_we   = 1'b1;
                acc_wdat = slew_q;
            end
            ST_WR_CODE: begin
                acc_ofs  = OFS_CODE;
                acc_we   = 1'b1;
                acc_wdat = code_q;
            end
            ST_WR_CARR: begin
                acc_ofs  = OFS_CARR;
                acc_we   = 1'b1;
                acc_wdat = carr_q;
            end
            default:       acc_ofs = OFS_PRN;
        endcase
    end

    wb_single_access #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_access (
        .clk      (clk),
        .rst      (hw_rst),
        .start    (acc_start),
        .we       (acc_we),
        .adr      (acc_adr),
        .wdat     (acc_wdat),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_ack_i (wb_ack_i),
        .wb_dat_i (wb_dat_i),
        .done     (acc_done),
        .err      (acc_err),
        .rdata    (acc_rdata)
    );

    // Both handshakes: a transfer happens on the clock edge where valid and
    // ready are both high; valid side holds its payload stable until then.
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            state       <= ST_IDLE;
            int_d       <= 1'b0;
            issued      <= 1'b0;
            dump_valid  <= 1'b0;
            dump_corr   <= '0;
            dump_status <= '0;
            upd_ready   <= 1'b0;
            err_timeout <= 1'b0;
            missed_int  <= 1'b0;
            slew_q      <= '0;
            code_q      <= '0;
            carr_q      <= '0;
        end else begin
            int_d       <= accum_int;
            err_timeout <= 1'b0;
            missed_int  <= 1'b0;
            if (int_evt && enable && state != ST_IDLE)
                missed_int <= 1'b1;
            if (acc_start)
                issued <= 1'b1;
            if (acc_done || acc_err)
                issued <= 1'b0;

            if (acc_err) begin
                err_timeout <= 1'b1;
                state       <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE:
                        if (int_evt && enable) state <= ST_RD_STAT;
                    ST_RD_STAT:
                        if (acc_done) begin
                            dump_status <= acc_rdata;
                            state       <= ST_RD_NEWDATA;
                        end
                    ST_RD_NEWDATA:
                        if (acc_done) state <= acc_rdata[0] ? ST_RD_IE : ST_IDLE;
                    ST_RD_IE:
                        if (acc_done) begin
                            dump_corr[CORR_IE*CORR_W +: CORR_W] <= acc_rdata;
                            state <= ST_RD_QE;
                        end
                    ST_RD_QE:
                        if (acc_done) begin
                            dump_corr[CORR_QE*CORR_W +: CORR_W] <= acc_rdata;
                            state <= ST_RD_IP;
                        end
                    ST_RD_IP:
                        if (acc_done) begin
                            dump_corr[CORR_IP*CORR_W +: CORR_W] <= acc_rdata;
                            state <= ST_RD_QP;
                        end
                    ST_RD_QP:
                        if (acc_done) begin
                            dump_corr[CORR_QP*CORR_W +: CORR_W] <= acc_rdata;
                            state <= ST_RD_IL;
                        end
                    ST_RD_IL:
                        if (acc_done) begin
                            dump_corr[CORR_IL*CORR_W +: CORR_W] <= acc_rdata;
                            state <= ST_RD_QL;
                        end
                    ST_RD_QL:
                        if (acc_done) begin
                            dump_corr[CORR_QL*CORR_W +: CORR_W] <= acc_rdata;
                            dump_valid <= 1'b1;
                            state      <= ST_DUMP;
                        end
                    ST_DUMP:
                        if (dump_ready) begin
                            dump_valid <= 1'b0;
                            upd_ready  <= 1'b1;
                            state      <= ST_WAIT_UPD;
                        end
                    ST_WAIT_UPD:
                        if (upd_valid) begin
                            slew_q    <= upd_slew;
                            code_q    <= upd_code_freq;
                            carr_q    <= upd_carr_freq;
                            upd_ready <= 1'b0;
                            state     <= next_write(ST_WAIT_UPD, upd_slew,
                                                    upd_code_freq, upd_carr_freq);
                        end
                    ST_WR_SLEW:
                        if (acc_done) state <= next_write(ST_WR_SLEW, slew_q, code_q, carr_q);
                    ST_WR_CODE:
                        if (acc_done) state <= next_write(ST_WR_CODE, slew_q, code_q, carr_q);
                    ST_WR_CARR:
                        if (acc_done) state <= ST_IDLE;
                    default:
                        state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corr_dump_master.sv
// Directed bench for corr_dump_master: a Wishbone responder model, a bus and
// dump scoreboard fed from expected queues, and loop-filter handshake drivers.
module tb_corr_dump_master;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic         clk;
    logic         hw_rst;
    logic         enable;
    logic         accum_int;
    logic [31:0]  wb_adr_o;
    logic [31:0]  wb_dat_o;
    logic [31:0]  wb_dat_i;
    logic [3:0]   wb_sel_o;
    logic         wb_cyc_o;
    logic         wb_stb_o;
    logic         wb_we_o;
    logic         wb_ack_i;
    logic         dump_valid;
    logic         dump_ready;
    logic [191:0] dump_corr;
    logic [31:0]  dump_status;
    logic         upd_valid;
    logic         upd_ready;
    logic [31:0]  upd_slew;
    logic [31:0]  upd_code_freq;
    logic [31:0]  upd_carr_freq;
    logic         busy;
    logic         err_timeout;
    logic         missed_int;

    corr_dump_master dut (
        .clk           (clk),
        .hw_rst        (hw_rst),
        .enable        (enable),
        .accum_int     (accum_int),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_dat_i      (wb_dat_i),
        .wb_sel_o      (wb_sel_o),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_ack_i      (wb_ack_i),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_corr     (dump_corr),
        .dump_status   (dump_status),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_slew      (upd_slew),
        .upd_code_freq (upd_code_freq),
        .upd_carr_freq (upd_carr_freq),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .missed_int    (missed_int)
    );

    int checks = 0;
    int errors = 0;

    logic [64:0]  exp_bus_q[$];
    logic [223:0] exp_dump_q[$];

    logic [31:0] status_val;
    logic [31:0] newdata_val;
    logic [31:0] corr_mem [6];
    logic [31:0] no_ack_adr;
    logic [31:0] cfg_slew, cfg_code, cfg_carr;
    int          ready_delay;
    int          dumps_seen = 0;
    int          err_pulses = 0;
    int          missed_pulses = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- responder model ----------------
    function automatic logic [31:0] rd_value(input logic [31:0] a);
        int idx;
        if (a == BASE + 32'h380) return status_val;
        if (a == BASE + 32'h384) return newdata_val;
        if (a >= BASE + 32'h10 && a <= BASE + 32'h24) begin
            idx = int'((a - BASE - 32'h10) >> 2);
            return corr_mem[idx];
        end
        return 32'hDEAD_BEEF;
    endfunction

    initial begin : responder
        logic cyc_seen;
        cyc_seen = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_cyc_o && wb_stb_o) begin
                if (cyc_seen && !wb_ack_i && wb_adr_o != no_ack_adr) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = wb_we_o ? 32'h0 : rd_value(wb_adr_o);
                end else begin
                    wb_ack_i = 1'b0;
                end
                cyc_seen = 1'b1;
            end else begin
                wb_ack_i = 1'b0;
                cyc_seen = 1'b0;
            end
        end
    end

    // ---------------- consumer drivers ----------------
    initial begin : dump_consumer
        int rdy_wait;
        rdy_wait   = 0;
        dump_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dump_valid && !dump_ready) begin
                if (rdy_wait >= ready_delay) dump_ready = 1'b1;
                else rdy_wait++;
            end else if (!dump_valid) begin
                dump_ready = 1'b0;
                rdy_wait   = 0;
            end
        end
    end

    initial begin : upd_driver
        upd_valid     = 1'b0;
        upd_slew      = '0;
        upd_code_freq = '0;
        upd_carr_freq = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hw_rst || upd_valid) begin
                upd_valid = 1'b0;
            end else if (upd_ready) begin
                upd_valid     = 1'b1;
                upd_slew      = cfg_slew;
                upd_code_freq = cfg_code;
                upd_carr_freq = cfg_carr;
            end
        end
    end

    // ---------------- scoreboard / monitors ----------------
    logic        cyc_prev = 1'b0;
    logic        prev_read = 1'b0;
    logic        busy_break = 1'b1;
    int          hi_len = 0;
    int          lo_len = 0;
    logic [31:0] cur_adr = '0;

    always @(negedge clk) begin : bus_monitor
        logic [64:0] e;
        if (hw_rst) begin
            cyc_prev   = 1'b0;
            prev_read  = 1'b0;
            busy_break = 1'b1;
            hi_len     = 0;
        end else begin
            if (!busy) busy_break = 1'b1;
            if (wb_cyc_o && !cyc_prev) begin
                chk("bus_sel", 256'(wb_sel_o), 256'(4'hf));
                if (exp_bus_q.size() == 0) begin
                    chk("bus_unexpected_access", 256'({wb_we_o, wb_adr_o}), 256'(0));
                end else begin
                    e = exp_bus_q.pop_front();
                    chk("bus_access", 256'({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0}),
                        256'(e));
                end
                if (!busy_break && prev_read && !wb_we_o)
                    chk("bus_gap", 256'(lo_len), 256'(1));
                cur_adr    = wb_adr_o;
                prev_read  = !wb_we_o;
                busy_break = 1'b0;
                hi_len     = 1;
            end else if (wb_cyc_o) begin
                hi_len++;
            end else if (cyc_prev) begin
                chk("bus_cyc_len", 256'(hi_len), 256'((cur_adr == no_ack_adr) ? 16 : 2));
                lo_len = 1;
            end else begin
                lo_len++;
            end
            cyc_prev = wb_cyc_o;
        end
    end

    logic         dv_prev = 1'b0;
    logic         dr_prev = 1'b0;
    logic [191:0] dc_prev = '0;

    always @(negedge clk) begin : dump_monitor
        logic [223:0] e;
        if (err_timeout) err_pulses++;
        if (missed_int) missed_pulses++;
        if (hw_rst) begin
            dv_prev = 1'b0;
            dr_prev = 1'b0;
        end else begin
            if (dv_prev && !dr_prev && dump_valid)
                chk("dump_stable", 256'(dump_corr), 256'(dc_prev));
            if (dump_valid && dump_ready) begin
                dumps_seen++;
                if (exp_dump_q.size() == 0) begin
                    chk("dump_unexpected", 256'(dump_corr), 256'(0));
                end else begin
                    e = exp_dump_q.pop_front();
                    chk("dump_data", 256'({dump_status, dump_corr}), 256'(e));
                end
            end
            dv_prev = dump_valid;
            dr_prev = dump_ready;
            dc_prev = dump_corr;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic exp_reads(input int n);
        logic [31:0] ofs [8];
        ofs = '{32'h380, 32'h384, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
        for (int i = 0; i < n; i++) exp_bus_q.push_back({1'b0, BASE + ofs[i], 32'h0});
    endtask

    task automatic exp_write(input logic [31:0] ofs, input logic [31:0] data);
        if (data != 32'h0) exp_bus_q.push_back({1'b1, BASE + ofs, data});
    endtask

    task automatic fire_int();
        @(posedge clk);
        #1 accum_int = 1'b1;
        @(posedge clk);
        #1 accum_int = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > budget) begin
                chk({nm, "_idle_timeout"}, 256'(n), 256'(budget));
                break;
            end
        end
    endtask

    task automatic wait_access(input string nm, input logic [31:0] adr);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o && wb_stb_o && wb_adr_o == adr) break;
            n++;
            if (n > 200) begin
                chk({nm, "_access_timeout"}, 256'(wb_adr_o), 256'(adr));
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int n, d0, e0, m0;
        hw_rst      = 1'b1;
        enable      = 1'b1;
        accum_int   = 1'b0;
        status_val  = 32'hA5A5_0001;
        newdata_val = 32'h1;
        corr_mem    = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        no_ack_adr  = 32'hFFFF_FFFF;
        cfg_slew    = '0;
        cfg_code    = '0;
        cfg_carr    = '0;
        ready_delay = 3;
        repeat (3) @(negedge clk);
        chk("rst_cyc_stb_we", 256'({wb_cyc_o, wb_stb_o, wb_we_o}), 256'(0));
        chk("rst_adr_dat", 256'({wb_adr_o, wb_dat_o}), 256'(0));
        chk("rst_dump", 256'({dump_valid, dump_status, dump_corr}), 256'(0));
        chk("rst_flags", 256'({upd_ready, busy, err_timeout, missed_int}), 256'(0));
        hw_rst = 1'b0;
        repeat (2) @(negedge clk);

        // read path, consumer stalls three cycles before accepting
        exp_reads(8);
        exp_dump_q.push_back({32'hA5A5_0001, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        d0 = dumps_seen;
        fire_int();
        wait_idle("read_path", 300, n);
        chk("read_path_dumps", 256'(dumps_seen - d0), 256'(1));

        // enable low: edge ignored entirely
        enable = 1'b0;
        m0 = missed_pulses;
        fire_int();
        repeat (4) @(negedge clk);
        chk("disabled_busy", 256'(busy), 256'(0));
        chk("disabled_missed", 256'(missed_pulses - m0), 256'(0));
        enable = 1'b1;

        // no new data: two reads then idle
        newdata_val = 32'h0;
        exp_reads(2);
        d0 = dumps_seen;
        fire_int();
        wait_idle("no_data", 100, n);
        chk("no_data_busy_cycles", 256'(n), 256'(6));
        repeat (3) @(negedge clk);
        chk("no_data_dumps", 256'(dumps_seen - d0), 256'(0));

        // write-back with all three words, new_data=3
        newdata_val = 32'h3;
        status_val  = 32'h0000_0F3C;
        corr_mem    = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
                        32'h8000_0000, 32'h1234_5678, 32'h0};
        ready_delay = 0;
        cfg_slew    = 32'h0000_060E;
        cfg_code    = 32'h015D_2F1A;
        cfg_carr    = 32'h033A_06D3;
        exp_reads(8);
        exp_dump_q.push_back({32'h0000_0F3C, 32'h0, 32'h1234_5678, 32'h8000_0000,
                              32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF});
        exp_write(32'h0C, 32'h0000_060E);
        exp_write(32'h08, 32'h015D_2F1A);
        exp_write(32'h04, 32'h033A_06D3);
        fire_int();
        wait_idle("writeback", 300, n);

        // slew zero is skipped
        cfg_slew = 32'h0;
        exp_reads(8);
        exp_dump_q.push_back({32'h0000_0F3C, 32'h0, 32'h1234_5678, 32'h8000_0000,
                              32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF});
        exp_write(32'h08, 32'h015D_2F1A);
        exp_write(32'h04, 32'h033A_06D3);
        fire_int();
        wait_idle("writeback_noslew", 300, n);
        chk("writeback_queue_drained", 256'(exp_bus_q.size()), 256'(0));

        // timeout on RD_IP, then a normal service
        cfg_code    = '0;
        cfg_carr    = '0;
        newdata_val = 32'h1;
        status_val  = 32'hA5A5_0001;
        corr_mem    = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        no_ack_adr  = BASE + 32'h18;
        exp_reads(5);
        d0 = dumps_seen;
        e0 = err_pulses;
        fire_int();
        wait_idle("timeout", 300, n);
        repeat (2) @(negedge clk);
        chk("timeout_err_pulses", 256'(err_pulses - e0), 256'(1));
        chk("timeout_dumps", 256'(dumps_seen - d0), 256'(0));
        no_ack_adr = 32'hFFFF_FFFF;
        exp_reads(8);
        exp_dump_q.push_back({32'hA5A5_0001, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        fire_int();
        wait_idle("after_timeout", 300, n);
        chk("after_timeout_dumps", 256'(dumps_seen - d0), 256'(1));

        // second edge during RD_QE is dropped with one missed_int pulse
        exp_reads(8);
        exp_dump_q.push_back({32'hA5A5_0001, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        d0 = dumps_seen;
        m0 = missed_pulses;
        fire_int();
        wait_access("missed", BASE + 32'h14);
        fire_int();
        wait_idle("missed", 300, n);
        repeat (10) @(negedge clk);
        chk("missed_pulses", 256'(missed_pulses - m0), 256'(1));
        chk("missed_dumps", 256'(dumps_seen - d0), 256'(1));
        chk("missed_busy", 256'(busy), 256'(0));

        // reset while RD_QP strobe is out
        exp_reads(6);
        fire_int();
        wait_access("reset", BASE + 32'h1C);
        #2 hw_rst = 1'b1;
        #1;
        chk("reset_mid_cyc_stb_valid", 256'({wb_cyc_o, wb_stb_o, dump_valid}), 256'(0));
        repeat (2) @(negedge clk);
        hw_rst = 1'b0;
        @(negedge clk);
        chk("reset_release_busy", 256'(busy), 256'(0));
        exp_reads(8);
        exp_dump_q.push_back({32'hA5A5_0001, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        d0 = dumps_seen;
        fire_int();
        wait_idle("after_reset", 300, n);
        chk("after_reset_dumps", 256'(dumps_seen - d0), 256'(1));

        repeat (5) @(negedge clk);
        chk("final_bus_queue", 256'(exp_bus_q.size()), 256'(0));
        chk("final_dump_queue", 256'(exp_dump_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
